// File: rtl/inst_loader.sv
// rtl/inst_loader.sv - assembles switch bytes into 32-bit words and writes them to instruction memory
module inst_loader #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        sw,
    input  logic              load,
    input  logic              clear,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [31:0]       wdata,
    output logic [1:0]        byte_idx,
    output logic [7:0]        LED,
    output logic              full
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        WRITE   = 2'd1,
        FULL    = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t state;
    state_t state_nxt;
    logic   load_q;
    logic   load_evt;

    // Only the 0->1 transition of the strobe counts, so a held button captures once
    assign load_evt = load & ~load_q;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; clear overrides every other transition
    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = COLLECT;
        end else begin
            case (state)
                COLLECT: if (load_evt && byte_idx == 2'd3) state_nxt = WRITE;
                WRITE:   state_nxt = (addr == ADDR_LAST) ? FULL : COLLECT;
                FULL:    state_nxt = FULL;
                default: state_nxt = COLLECT;
            endcase
        end
    end

    // Datapath registers: byte capture, write pulse, address advance and full flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_q   <= 1'b0;
            we       <= 1'b0;
            addr     <= '0;
            wdata    <= '0;
            byte_idx <= 2'd0;
            LED      <= 8'd0;
            full     <= 1'b0;
        end else begin
            load_q <= load;
            if (clear) begin
                // LED deliberately keeps the last byte shown to the user
                we       <= 1'b0;
                addr     <= '0;
                wdata    <= '0;
                byte_idx <= 2'd0;
                full     <= 1'b0;
            end else begin
                case (state)
                    COLLECT: begin
                        if (load_evt) begin
                            wdata[{byte_idx, 3'b000} +: 8] <= sw;
                            LED      <= sw;
                            byte_idx <= byte_idx + 2'd1;
                            // Raising we with the last byte gives a one-cycle pulse in WRITE
                            we       <= (byte_idx == 2'd3);
                        end
                    end
                    WRITE: begin
                        we <= 1'b0;
                        if (addr == ADDR_LAST) begin
                            full <= 1'b1;
                        end else begin
                            addr <= addr + ADDR_ONE;
                        end
                    end
                    default: begin
                        we <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/inst_loader.md
INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 6, giving the instruction-memory word-address width (2^ADDR_W words).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, an asynchronous active-low reset.
REQ-004 The block SHALL have port sw, input, 8 bits, the instruction byte from the board switches.
REQ-005 The block SHALL have port load, input, 1 bit, the byte-capture strobe, synchronous and already debounced; only its rising edge is significant.
REQ-006 The block SHALL have port clear, input, 1 bit, a synchronous restart request.
REQ-007 The block SHALL have port we, output, 1 bit, the instruction-memory write enable.
REQ-008 The block SHALL have port addr, output, ADDR_W bits, the instruction-memory word address.
REQ-009 The block SHALL have port wdata, output, 32 bits, the instruction word to write.
REQ-010 The block SHALL have port byte_idx, output, 2 bits, the index of the next byte to capture.
REQ-011 The block SHALL have port LED, output, 8 bits, an echo of the last captured byte.
REQ-012 The block SHALL have port full, output, 1 bit, set when every memory word has been written.
REQ-013 All outputs SHALL be driven directly from registers.

Function
REQ-014 The state machine SHALL have exactly three states: COLLECT, WRITE and FULL.
REQ-015 The block SHALL register load into load_q every cycle, and SHALL generate a load event in any cycle where load=1 and load_q=0.
REQ-016 In COLLECT, a load event SHALL write sw into wdata[8*byte_idx+7 : 8*byte_idx], copy sw to LED, and increment byte_idx modulo 4, all at the same clock edge.
REQ-017 Byte order SHALL be little-endian: the first byte goes to [7:0] and the fourth byte to [31:24].
REQ-018 A load event in COLLECT with byte_idx=3 SHALL capture the byte, set byte_idx to 0, and move the state to WRITE at the same edge.
REQ-019 In WRITE, we SHALL be 1 for exactly one cycle, with wdata and addr stable and holding the completed word.
REQ-020 At the clock edge that ends WRITE, we SHALL return to 0.
REQ-021 At the edge that ends WRITE, if addr is below 2^ADDR_W-1, addr SHALL increment and the state SHALL return to COLLECT.
REQ-022 At the edge that ends WRITE, if addr equals 2^ADDR_W-1, addr SHALL hold, full SHALL be set to 1, and the state SHALL move to FULL; addr SHALL never wrap implicitly.
REQ-023 Latency from the fourth load event edge to we=1 SHALL be one cycle.
REQ-024 Load events during WRITE or FULL SHALL be ignored: no capture, and no change to byte_idx or LED.
REQ-025 wdata SHALL retain its previous word contents across writes, and bytes are overwritten only as they are captured.
REQ-026 FULL SHALL be held indefinitely until clear or reset.
REQ-027 clear=1 in any state SHALL, at the next edge, set the state to COLLECT, addr to 0, byte_idx to 0, wdata to 0, full to 0 and we to 0; LED SHALL hold its value.
REQ-028 clear SHALL take priority over a simultaneous load event or WRITE completion.
REQ-029 A WRITE cycle coinciding with clear SHALL still present we=1 during that cycle, and SHALL then neither increment addr nor set full.
REQ-030 If load is held at 1 continuously, it SHALL produce only one event, and a new event SHALL require load to return to 0 first.

Reset
REQ-031 When rst=0, the block SHALL immediately, without waiting for a clock edge, force state=COLLECT, we=0, addr=0, wdata=0, byte_idx=0, LED=0, full=0 and load_q=0.
REQ-032 Reset asserted mid-word or during WRITE SHALL abort that word, with no write completed after reset.
REQ-033 Operation SHALL resume at the first clock edge after rst returns to 1.
REQ-034 A load held at 1 through reset release SHALL produce one event at the first edge after release, because load_q resets to 0.

Verification
REQ-035 The bench SHALL cover: sw=0x13, 0x00, 0x40, 0x8C on four load pulses -> byte_idx steps 1, 2, 3, 0; LED follows each byte; one cycle later we=1 with addr=0 and wdata=0x8C400013; the next cycle addr=1 and we=0.
REQ-036 The bench SHALL cover: load held high for 10 cycles with sw=0xAA -> exactly one capture, and byte_idx advances by 1 only.
REQ-037 The bench SHALL cover: writing 64 words with ADDR_W=6 -> the final write occurs at addr=63, then full=1 and addr stays at 63; a further load pulse causes no change to LED or byte_idx.
REQ-038 The bench SHALL cover: clear asserted in FULL, or after two bytes of a word -> next edge gives addr=0, byte_idx=0, wdata=0, full=0; a following four-byte sequence writes to addr 0.
REQ-039 The bench SHALL cover: clear asserted in the WRITE cycle of word 5 -> we=1 for that cycle, then addr=0 with no increment to 6.
REQ-040 The bench SHALL cover: rst driven low asynchronously between clock edges mid-word -> all outputs are 0 immediately, and after release the first four load pulses form a word written to addr 0.
